// File: rtl/hi_lo_unit_if.sv
// ---------------------------------------------------------------------------
// hi_lo_unit_if
// Bundles the execute-stage signals exchanged between the pipeline/ALU side
// (master) and the HI/LO register unit (slave).
//
// Signals:
//   op_valid      - execute-stage instruction commits this cycle
//   alu_operation - 6-bit ALU function code of that instruction
//   alu_hi_in     - ALU HI result / operand output
//   alu_lo_in     - ALU LO result / operand output
//   alu_stall     - ALU multi-cycle operation in progress
//   hi_out        - architectural HI register
//   lo_out        - architectural LO register
//   hilo_busy     - unit is tracking a pending multiply/divide
//   hilo_stall    - hold the pipeline for a HI/LO hazard
// ---------------------------------------------------------------------------
interface hi_lo_unit_if;
    logic        op_valid;
    logic [5:0]  alu_operation;
    logic [31:0] alu_hi_in;
    logic [31:0] alu_lo_in;
    logic        alu_stall;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        hilo_busy;
    logic        hilo_stall;

    modport master (
        output op_valid,
        output alu_operation,
        output alu_hi_in,
        output alu_lo_in,
        output alu_stall,
        input  hi_out,
        input  lo_out,
        input  hilo_busy,
        input  hilo_stall
    );

    modport slave (
        input  op_valid,
        input  alu_operation,
        input  alu_hi_in,
        input  alu_lo_in,
        input  alu_stall,
        output hi_out,
        output lo_out,
        output hilo_busy,
        output hilo_stall
    );
endinterface

// File: rtl/hi_lo_unit.sv
// ---------------------------------------------------------------------------
// hi_lo_unit
// Architectural HI/LO register pair and multiply/divide interlock. Captures
// the ALU HI/LO outputs when a MULT/MULTU/DIV/DIVU completes or immediately
// on MTHI/MTLO, and stalls HI/LO-dependent instructions while a multi-cycle
// result is pending.
//
// Parameters:
//   START_TIMEOUT - cycles spent in ARM waiting for alu_stall to rise before
//                   the operation is treated as single-cycle
//
// Ports:
//   clk   - rising-edge clock shared with the ALU
//   reset - asynchronous reset, active low
//   bus   - slave side of hi_lo_unit_if (op_valid, alu_operation, alu_hi_in,
//           alu_lo_in, alu_stall in; hi_out, lo_out, hilo_busy, hilo_stall out)
// ---------------------------------------------------------------------------
module hi_lo_unit #(
    parameter int START_TIMEOUT = 2
) (
    input logic          clk,
    input logic          reset,
    hi_lo_unit_if.slave  bus
);

    localparam int CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(START_TIMEOUT - 1);

    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] arm_cnt_q, arm_cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic isLong;
    logic isMthi;
    logic isMtlo;
    logic isRead;
    logic isHiloOp;

    // Op-class decode of the ALU function code.
    always_comb begin
        isLong   = (bus.alu_operation == OP_MULT)  || (bus.alu_operation == OP_MULTU) ||
                   (bus.alu_operation == OP_DIV)   || (bus.alu_operation == OP_DIVU);
        isMthi   = (bus.alu_operation == OP_MTHI);
        isMtlo   = (bus.alu_operation == OP_MTLO);
        isRead   = (bus.alu_operation == OP_MFHI)  || (bus.alu_operation == OP_MFLO);
        isHiloOp = isLong || isMthi || isMtlo || isRead;
    end

    // State, ARM counter and HI/LO registers. Reset abandons any pending result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            arm_cnt_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Next-state and register-update logic. Only IDLE acts on op_valid;
    // any HI/LO op arriving in ARM/BUSY is stalled and writes nothing.
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    if (isLong) begin
                        state_d   = ARM;
                        arm_cnt_d = '0;
                    end else if (isMthi) begin
                        // The ALU drives input_1 on both outputs; MTHI takes HI only.
                        hi_d = bus.alu_hi_in;
                    end else if (isMtlo) begin
                        lo_d = bus.alu_lo_in;
                    end
                end
            end
            ARM: begin
                // Waits out the ALU's registered start-enable; if the stall never
                // rises the ALU finished in one cycle and its outputs are final.
                if (bus.alu_stall) begin
                    state_d = BUSY;
                end else if (arm_cnt_q == LAST_CNT) begin
                    hi_d      = bus.alu_hi_in;
                    lo_d      = bus.alu_lo_in;
                    arm_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    arm_cnt_d = arm_cnt_q + CNT_W'(1);
                end
            end
            BUSY: begin
                if (!bus.alu_stall) begin
                    hi_d    = bus.alu_hi_in;
                    lo_d    = bus.alu_lo_in;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                arm_cnt_d = '0;
            end
        endcase
    end

    assign bus.hi_out     = hi_q;
    assign bus.lo_out     = lo_q;
    assign bus.hilo_busy  = (state_q != IDLE);
    assign bus.hilo_stall = bus.op_valid && isHiloOp && (state_q != IDLE);

endmodule

// File: tb/tb_hi_lo_unit.sv
// ---------------------------------------------------------------------------
// tb_hi_lo_unit
// Self-checking bench for hi_lo_unit: directed scenarios followed by a
// randomized run, all checked against a pending-operation reference model.
// ---------------------------------------------------------------------------
module tb_hi_lo_unit;

    localparam int START_TIMEOUT = 2;

    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_ADDU  = 6'b100001;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    hi_lo_unit_if bus ();

    hi_lo_unit #(.START_TIMEOUT(START_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a long op is "pending" from its issue until the ALU
    // either finishes a stall period or never stalls within the timeout.
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;
    bit          mPending = 1'b0;
    bit          mSawStall = 1'b0;
    int          mAge = 0;

    function automatic bit isLongOp(input logic [5:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    endfunction

    function automatic bit isHiloOp(input logic [5:0] op);
        return isLongOp(op) || (op inside {OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO});
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mHi = '0; mLo = '0; mPending = 1'b0; mSawStall = 1'b0; mAge = 0;
        end else if (mPending) begin
            if (bus.alu_stall) begin
                mSawStall = 1'b1;
            end else if (mSawStall || mAge == START_TIMEOUT - 1) begin
                mHi = bus.alu_hi_in;
                mLo = bus.alu_lo_in;
                mPending = 1'b0;
            end else begin
                mAge++;
            end
        end else if (bus.op_valid) begin
            if (isLongOp(bus.alu_operation)) begin
                mPending = 1'b1; mSawStall = 1'b0; mAge = 0;
            end else if (bus.alu_operation == OP_MTHI) begin
                mHi = bus.alu_hi_in;
            end else if (bus.alu_operation == OP_MTLO) begin
                mLo = bus.alu_lo_in;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [5:0] op,
                                 input logic [31:0] hiIn, input logic [31:0] loIn,
                                 input logic stall);
        bus.op_valid      = v;
        bus.alu_operation = op;
        bus.alu_hi_in     = hiIn;
        bus.alu_lo_in     = loIn;
        bus.alu_stall     = stall;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, OP_MFHI, 32'h1, 32'h2, 1'b0);
        #3;
        checks++;
        if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_hilo: got hi=%h lo=%h expected 0/0", bus.hi_out, bus.lo_out);
        end
        checks++;
        if (bus.hilo_busy !== 1'b0 || bus.hilo_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got busy=%b stall=%b expected 0/0", bus.hilo_busy, bus.hilo_stall);
        end
        @(posedge clk);
        #1;
        applyStimulus(1'b0, OP_ADDU, 32'h0, 32'h0, 1'b0);
        reset = 1'b1;
    endtask

    task automatic test_mt_ops();
        applyStimulus(1'b1, OP_MTHI, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        cycle();
        applyStimulus(1'b1, OP_MFHI, 32'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if (bus.hi_out !== 32'hDEADBEEF || bus.lo_out !== 32'h0 || bus.hilo_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mthi: got hi=%h lo=%h stall=%b expected deadbeef/0/0", bus.hi_out, bus.lo_out, bus.hilo_stall);
        end
        applyStimulus(1'b1, OP_MTLO, 32'h12345678, 32'h12345678, 1'b0);
        cycle();
        checks++;
        if (bus.lo_out !== 32'h12345678 || bus.hi_out !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL mtlo: got hi=%h lo=%h expected deadbeef/12345678", bus.hi_out, bus.lo_out);
        end
        // Drive into BUSY, then reset asynchronously mid-cycle.
        applyStimulus(1'b1, OP_MULT, 32'h0, 32'h0, 1'b0);
        cycle();
        applyStimulus(1'b0, OP_ADDU, 32'h0, 32'h0, 1'b1);
        cycle();
        checks++;
        if (bus.hilo_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_before_reset: got %b expected 1", bus.hilo_busy);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0 || bus.hilo_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got hi=%h lo=%h busy=%b expected 0/0/0", bus.hi_out, bus.lo_out, bus.hilo_busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, OP_MTHI, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        cycle();
        applyStimulus(1'b0, OP_ADDU, 32'h0, 32'h0, 1'b0);
        checks++;
        if (bus.hi_out !== 32'hDEADBEEF || bus.lo_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mthi_after_reset: got hi=%h lo=%h expected deadbeef/0", bus.hi_out, bus.lo_out);
        end
    endtask

    task automatic test_mult_capture();
        logic [31:0] oldHi;
        oldHi = bus.hi_out;
        applyStimulus(1'b1, OP_MULT, 32'h0, 32'h0, 1'b0);
        cycle();
        checks++;
        if (bus.hilo_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mult_busy_rise: got %b expected 1", bus.hilo_busy);
        end
        applyStimulus(1'b0, OP_ADDU, 32'h0, 32'h0, 1'b0);
        cycle();
        bus.alu_stall = 1'b1;
        for (int i = 0; i < 32; i++) cycle();
        checks++;
        if (bus.hilo_busy !== 1'b1 || bus.hi_out !== oldHi) begin
            errors++;
            $display("[TB] FAIL mult_pending: got busy=%b hi=%h expected 1/%h", bus.hilo_busy, bus.hi_out, oldHi);
        end
        applyStimulus(1'b0, OP_ADDU, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        cycle();
        checks++;
        if (bus.hi_out !== 32'hFFFFFFFF || bus.lo_out !== 32'hFFFFFFFA || bus.hilo_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mult_capture: got hi=%h lo=%h busy=%b expected ffffffff/fffffffa/0", bus.hi_out, bus.lo_out, bus.hilo_busy);
        end
    endtask

    task automatic test_read_interlock();
        applyStimulus(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
        cycle();
        applyStimulus(1'b0, OP_ADDU, 32'h0, 32'h0, 1'b0);
        cycle();
        bus.alu_stall = 1'b1;
        cycle();
        cycle();
        applyStimulus(1'b1, OP_MFLO, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.hilo_stall !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mflo_stall_%0d: got %b expected 1", i, bus.hilo_stall);
            end
            cycle();
        end
        bus.alu_stall = 1'b0;
        bus.alu_hi_in = 32'd2;
        bus.alu_lo_in = 32'd14;
        #1;
        checks++;
        if (bus.hilo_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mflo_stall_capture: got %b expected 1", bus.hilo_stall);
        end
        cycle();
        checks++;
        if (bus.hilo_stall !== 1'b0 || bus.lo_out !== 32'd14 || bus.hi_out !== 32'd2) begin
            errors++;
            $display("[TB] FAIL mflo_release: got stall=%b hi=%0d lo=%0d expected 0/2/14", bus.hilo_stall, bus.hi_out, bus.lo_out);
        end
        applyStimulus(1'b0, OP_ADDU, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_arm_timeout();
        applyStimulus(1'b1, OP_DIV, 32'd5, 32'd9, 1'b0);
        cycle();
        bus.op_valid = 1'b0;
        cycle();
        checks++;
        if (bus.hilo_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL arm_busy: got %b expected 1", bus.hilo_busy);
        end
        cycle();
        checks++;
        if (bus.hi_out !== 32'd5 || bus.lo_out !== 32'd9 || bus.hilo_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL arm_timeout: got hi=%0d lo=%0d busy=%b expected 5/9/0", bus.hi_out, bus.lo_out, bus.hilo_busy);
        end
    endtask

    task automatic test_hazard_isolation();
        logic [31:0] oldLo;
        oldLo = bus.lo_out;
        applyStimulus(1'b1, OP_MULT, 32'h0, 32'h0, 1'b0);
        cycle();
        applyStimulus(1'b0, OP_ADDU, 32'h0, 32'h0, 1'b1);
        cycle();
        applyStimulus(1'b1, OP_ADDU, 32'h0, 32'h0, 1'b1);
        #1;
        checks++;
        if (bus.hilo_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL addu_no_stall: got %b expected 0", bus.hilo_stall);
        end
        cycle();
        applyStimulus(1'b1, OP_MTLO, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1);
        #1;
        checks++;
        if (bus.hilo_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mtlo_stall: got %b expected 1", bus.hilo_stall);
        end
        cycle();
        cycle();
        checks++;
        if (bus.lo_out !== oldLo) begin
            errors++;
            $display("[TB] FAIL mtlo_no_write: got lo=%h expected %h", bus.lo_out, oldLo);
        end
        applyStimulus(1'b1, OP_MTLO, 32'h00002222, 32'h00001111, 1'b0);
        cycle();
        checks++;
        if (bus.lo_out !== 32'h00001111 || bus.hi_out !== 32'h00002222 || bus.hilo_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mtlo_after_capture: got hi=%h lo=%h stall=%b expected 2222/1111/0", bus.hi_out, bus.lo_out, bus.hilo_stall);
        end
        bus.alu_hi_in = 32'hA5A5A5A5;
        bus.alu_lo_in = 32'hA5A5A5A5;
        cycle();
        applyStimulus(1'b0, OP_ADDU, 32'h0, 32'h0, 1'b0);
        checks++;
        if (bus.lo_out !== 32'hA5A5A5A5 || bus.hi_out !== 32'h00002222) begin
            errors++;
            $display("[TB] FAIL mtlo_overwrite: got hi=%h lo=%h expected 2222/a5a5a5a5", bus.hi_out, bus.lo_out);
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, OP_MULT, 32'h0, 32'h0, 1'b0);
        cycle();
        applyStimulus(1'b1, OP_MULTU, 32'h80000000, 32'h2, 1'b0);
        #1;
        checks++;
        if (bus.hilo_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_stall_arm: got %b expected 1", bus.hilo_stall);
        end
        cycle();
        bus.alu_stall = 1'b1;
        cycle();
        cycle();
        checks++;
        if (bus.hilo_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_stall_busy: got %b expected 1", bus.hilo_stall);
        end
        applyStimulus(1'b1, OP_MULTU, 32'h3, 32'h4, 1'b0);
        cycle();
        checks++;
        if (bus.hilo_stall !== 1'b0 || bus.hi_out !== 32'h3 || bus.lo_out !== 32'h4) begin
            errors++;
            $display("[TB] FAIL b2b_first_done: got stall=%b hi=%h lo=%h expected 0/3/4", bus.hilo_stall, bus.hi_out, bus.lo_out);
        end
        cycle();
        applyStimulus(1'b0, OP_ADDU, 32'h0, 32'h0, 1'b0);
        cycle();
        bus.alu_stall = 1'b1;
        cycle();
        cycle();
        applyStimulus(1'b0, OP_ADDU, 32'h1, 32'h0, 1'b0);
        cycle();
        checks++;
        if (bus.hi_out !== 32'h1 || bus.lo_out !== 32'h0 || bus.hilo_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_second_result: got hi=%h lo=%h busy=%b expected 1/0/0", bus.hi_out, bus.lo_out, bus.hilo_busy);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [9];
        bit         hold;
        bit         expStall;
        ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO, OP_ADDU};
        hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            checks++;
            if (bus.hi_out !== mHi || bus.lo_out !== mLo || bus.hilo_busy !== mPending) begin
                errors++;
                $display("[TB] FAIL rand_regs_%0d: got hi=%h lo=%h busy=%b expected %h/%h/%b",
                         i, bus.hi_out, bus.lo_out, bus.hilo_busy, mHi, mLo, mPending);
            end
            if (!hold) begin
                bus.op_valid      = ($urandom_range(0, 2) != 0);
                bus.alu_operation = ops[$urandom_range(0, 8)];
            end
            bus.alu_hi_in = $urandom;
            bus.alu_lo_in = $urandom;
            bus.alu_stall = ($urandom_range(0, 3) != 0);
            #1;
            expStall = bus.op_valid && isHiloOp(bus.alu_operation) && mPending;
            checks++;
            if (bus.hilo_stall !== expStall) begin
                errors++;
                $display("[TB] FAIL rand_stall_%0d: got %b expected %b", i, bus.hilo_stall, expStall);
            end
            hold = expStall;
            cycle();
        end
        applyStimulus(1'b0, OP_ADDU, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic checkOutput();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, OP_ADDU, 32'h0, 32'h0, 1'b0);
        test_reset();
        test_mt_ops();
        test_mult_capture();
        test_read_interlock();
        test_arm_timeout();
        test_hazard_isolation();
        test_back_to_back();
        test_random();
        checkOutput();
        $finish;
    end

endmodule

// File: doc/hi_lo_unit.md
# hi_lo_unit

Architectural HI/LO register pair and multiply/divide interlock, sitting directly downstream of the ALU in the execute stage. Captures the ALU's `ALU_HI_output`/`ALU_LO_output` when a MULT/MULTU/DIV/DIVU completes, or immediately on MTHI/MTLO. Drives HI/LO back to the ALU operand path for MFHI/MFLO. Stalls HI/LO-dependent instructions while a multi-cycle result is pending.

## Interface
- `START_TIMEOUT`, 2: cycles the unit waits in ARM for `alu_stall` to rise before treating the operation as single-cycle.
- `clk  in  1  rising-edge clock shared with the ALU`
- `reset  in  1  asynchronous, active-low; 0 = reset asserted`
- `op_valid  in  1  execute-stage instruction commits this cycle (fetch_state_next == 3'b100 qualifier)`
- `alu_operation  in  6  same function encoding the ALU receives`
- `alu_hi_in  in  32  ALU_HI_output`
- `alu_lo_in  in  32  ALU_LO_output`
- `alu_stall  in  1  ALU_STALL`
- `hi_out  out  32  architectural HI register`
- `lo_out  out  32  architectural LO register`
- `hilo_busy  out  1  high whenever state != IDLE`
- `hilo_stall  out  1  combinational; holds the pipeline for a HI/LO hazard`

## Operation
- Op classes, decoded from `alu_operation`:
  - LONG = 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
  - MTHI = 010001; MTLO = 010011.
  - READ = 010000 MFHI, 010010 MFLO.
  - HILO_OP = LONG | MTHI | MTLO | READ.
- States: IDLE, ARM, BUSY. Each transition happens on a rising `clk`.
  - IDLE: `op_valid` and LONG → ARM, with `arm_cnt` = 0. `op_valid` and MTHI → HI <= `alu_hi_in`. `op_valid` and MTLO → LO <= `alu_lo_in`. The ALU places input_1 on both HI and LO outputs, so each op writes only its own register. READ needs no state change.
  - ARM: covers the ALU's registered start-enable latency.
    - `alu_stall` = 1 → BUSY.
    - Otherwise `arm_cnt`++.
    - `arm_cnt` == `START_TIMEOUT`-1 with `alu_stall` still 0 → capture HI <= `alu_hi_in`, LO <= `alu_lo_in`, go to IDLE.
  - BUSY: `alu_stall` = 1 → stay. `alu_stall` = 0 → capture HI <= `alu_hi_in` and LO <= `alu_lo_in` on that same edge, go to IDLE.
- `hilo_stall` = `op_valid` & HILO_OP & (state != IDLE). While stalled, the upstream pipeline holds `op_valid` and `alu_operation` stable. No register writes happen on behalf of a stalled op.
- Results are captured unmodified, including DIV/DIVU by zero, whose values come from the divider. No width change: 32-bit copies only.
- `hi_out` and `lo_out` come directly from the registers; there is no bypass.

## Timing
- Reset (reset = 0, asynchronous): HI = 0, LO = 0, state = IDLE, `arm_cnt` = 0. `hilo_busy` = 0 and `hilo_stall` = 0 immediately, without waiting for a clock edge. Reset during ARM or BUSY abandons the pending result.
- MTHI/MTLO: 1-cycle latency. An MFHI in the next cycle reads the new value.
- LONG: `hilo_busy` rises the cycle after issue. The result is visible on `hi_out`/`lo_out` in the cycle after `alu_stall` is sampled low in BUSY.
- Capture edge: `hilo_stall` is still 1 in the capture cycle. A waiting READ proceeds in the following cycle and sees the new value.
- Back-to-back LONG ops: the second one stalls until IDLE, then issues normally.
- Non-HILO ops (ADD etc.) never stall, in any state.
- `op_valid` = 0: no state change in IDLE. ARM and BUSY continue to advance independently of `op_valid`.

## Test plan
- Reset and MT ops: reset low mid-BUSY → `hi_out` = `lo_out` = 0 and `hilo_busy` = 0 with no clock edge. Then MTHI with `alu_hi_in` = 0xDEADBEEF → next cycle `hi_out` = 0xDEADBEEF and `lo_out` = 0.
- Multiply capture: MULT issue; `alu_stall` 0 for 1 cycle, then high for 32 cycles, then low with HI = 0xFFFFFFFF, LO = 0xFFFFFFFA → `hi_out`/`lo_out` show those values exactly one cycle after the stall falls, and `hilo_busy` drops on that same cycle.
- Read interlock: MFLO presented 3 cycles after a DIVU issue → `hilo_stall` = 1 until the capture cycle inclusive. Next cycle `hilo_stall` = 0 and `lo_out` = quotient (100/7 → 14, HI = 2).
- ARM timeout: LONG issue with `alu_stall` never rising, `alu_hi_in` = 5, `alu_lo_in` = 9, `START_TIMEOUT` = 2 → after 2 ARM cycles HI = 5, LO = 9, state IDLE.
- Hazard isolation: ADDU during BUSY → `hilo_stall` = 0. MTLO during BUSY → `hilo_stall` = 1 and LO unchanged; after completion, the MTLO value overwrites the captured LO on the next cycle.
- Back-to-back LONG: MULT followed immediately by MULTU → MULTU stalls until IDLE. Final HI/LO equal the MULTU result (0x80000000 × 2 → HI = 1, LO = 0).
